// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution address path.
//   IDLE/RUN/DONE : sequencer state encoding
//   out_dim()     : number of window positions along one axis
//   cnt_w()       : counter width able to hold 0..n-1, never zero bits wide
package cnn_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int out_dim(input int img, input int k, input int s);
        return (img - k) / s + 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/win_tap_counter.sv
// Two-level column/row tap counter for one KSIZE x KSIZE window.
// Keeps a row pointer, which is the image address of column 0 of the
// current kernel row.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart at tap (0,0) with row pointer = ptr_init
//   adv        : step to the next tap; on window wrap, reload ptr_init
//   ptr_init   : first-row address of the next window
//   c          : current column index
//   row_ptr    : address of column 0 of the current kernel row
//   wrap       : current tap is the last tap of the window
module win_tap_counter
    import cnn_pkg::*;
#(
    parameter  int KSIZE = 3,
    parameter  int IMG_W = 48,
    parameter  int AW_I  = 13,
    localparam int CW    = cnt_w(KSIZE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            adv,
    input  logic [AW_I-1:0] ptr_init,
    output logic [CW-1:0]   c,
    output logic [AW_I-1:0] row_ptr,
    output logic            wrap
);

    localparam logic [CW-1:0]   K_MAX = CW'(KSIZE - 1);
    localparam logic [AW_I-1:0] PITCH = AW_I'(IMG_W);

    logic [CW-1:0] r;
    logic          c_end;

    assign c_end = (c == K_MAX);
    assign wrap  = c_end && (r == K_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c       <= '0;
            r       <= '0;
            row_ptr <= '0;
        end else if (clear) begin
            c       <= '0;
            r       <= '0;
            row_ptr <= ptr_init;
        end else if (adv) begin
            if (!c_end) begin
                c <= c + CW'(1);
            end else begin
                c <= '0;
                if (r == K_MAX) begin
                    r       <= '0;
                    row_ptr <= ptr_init;
                end else begin
                    r       <= r + CW'(1);
                    row_ptr <= row_ptr + PITCH;
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Convolution window address generator. Sweeps every KSIZE x KSIZE tap
// of every output position of an IMG_H x IMG_W map at STRIDE, producing
// kernel and image addresses with incremental (multiplier-free) math.
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : begin a sweep (only honoured in IDLE)
//   base_w, base_i : base addresses, captured when start is accepted
//   ready          : consumer takes the current tap
//   valid          : addr_w/addr_i carry a tap
//   addr_w, addr_i : kernel and image addresses
//   last_tap       : last tap of the current window
//   last_out       : last tap of the final window
//   busy           : sweep in progress
//   done           : one-cycle pulse after the final transfer
//
// state | meaning
// IDLE  | waiting for start, outputs low
// RUN   | presenting taps, advancing on valid && ready
// DONE  | single-cycle done pulse, start ignored
module conv_window_addr_gen
    import cnn_pkg::*;
#(
    parameter int KSIZE  = 3,
    parameter int IMG_W  = 48,
    parameter int IMG_H  = 48,
    parameter int STRIDE = 1,
    parameter int AW_W   = 4,
    parameter int AW_I   = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW_W-1:0] base_w,
    input  logic [AW_I-1:0] base_i,
    input  logic            ready,
    output logic            valid,
    output logic [AW_W-1:0] addr_w,
    output logic [AW_I-1:0] addr_i,
    output logic            last_tap,
    output logic            last_out,
    output logic            busy,
    output logic            done
);

    localparam int OUT_W = out_dim(IMG_W, KSIZE, STRIDE);
    localparam int OUT_H = out_dim(IMG_H, KSIZE, STRIDE);
    localparam int CW    = cnt_w(KSIZE);
    localparam int XW    = cnt_w(OUT_W);
    localparam int YW    = cnt_w(OUT_H);

    localparam logic [AW_I-1:0] STEP_X = AW_I'(STRIDE);
    localparam logic [AW_I-1:0] STEP_Y = AW_I'(STRIDE * IMG_W);
    localparam logic [XW-1:0]   OX_MAX = XW'(OUT_W - 1);
    localparam logic [YW-1:0]   OY_MAX = YW'(OUT_H - 1);

    logic [1:0]      state, state_nxt;
    logic [AW_W-1:0] bw_q, aw_q;
    logic [AW_I-1:0] origin_q, row_start_q, next_origin, ptr_init, row_ptr;
    logic [XW-1:0]   ox_q;
    logic [YW-1:0]   oy_q;
    logic [CW-1:0]   c;
    logic            tap_wrap, ox_end, oy_end, accept, xfer;

    assign accept = (state == IDLE) && start;
    assign xfer   = (state == RUN) && ready;
    assign ox_end = (ox_q == OX_MAX);
    assign oy_end = (oy_q == OY_MAX);

    // Origin of the window that follows the current one: step right, or
    // drop STRIDE rows below the start of the current output row.
    assign next_origin = ox_end ? (row_start_q + STEP_Y) : (origin_q + STEP_X);
    assign ptr_init    = (state == IDLE) ? base_i : next_origin;

    win_tap_counter #(
        .KSIZE (KSIZE),
        .IMG_W (IMG_W),
        .AW_I  (AW_I)
    ) u_taps (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .adv      (xfer),
        .ptr_init (ptr_init),
        .c        (c),
        .row_ptr  (row_ptr),
        .wrap     (tap_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bw_q        <= '0;
            aw_q        <= '0;
            origin_q    <= '0;
            row_start_q <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
        end else if (accept) begin
            bw_q        <= base_w;
            aw_q        <= base_w;
            origin_q    <= base_i;
            row_start_q <= base_i;
            ox_q        <= '0;
            oy_q        <= '0;
        end else if (xfer) begin
            if (tap_wrap) begin
                aw_q     <= bw_q;
                origin_q <= next_origin;
                if (ox_end) begin
                    ox_q        <= '0;
                    row_start_q <= next_origin;
                    oy_q        <= oy_end ? '0 : oy_q + YW'(1);
                end else begin
                    ox_q <= ox_q + XW'(1);
                end
            end else begin
                aw_q <= aw_q + AW_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (ready && last_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        addr_w   = '0;
        addr_i   = '0;
        last_tap = 1'b0;
        last_out = 1'b0;
        case (state)
            RUN: begin
                valid    = 1'b1;
                busy     = 1'b1;
                addr_w   = aw_q;
                addr_i   = row_ptr + AW_I'(c);
                last_tap = tap_wrap;
                last_out = tap_wrap && ox_end && oy_end;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_conv_window_addr_gen.sv
module tb_conv_window_addr_gen;

    typedef struct packed {
        logic [3:0]  aw;
        logic [12:0] ai;
        logic        lt;
        logic        lo;
    } tap_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [3:0]  base_w;
    logic [12:0] base_i;
    logic        ready;

    logic [2:0]  valid_v, busy_v, done_v, lt_v, lo_v;
    logic [3:0]  aw_v [3];
    logic [12:0] ai_v [3];

    int sel;
    int checks = 0;
    int errors = 0;

    logic        o_valid, o_busy, o_done, o_lt, o_lo;
    logic [3:0]  o_aw;
    logic [12:0] o_ai;

    assign o_valid = valid_v[sel];
    assign o_busy  = busy_v[sel];
    assign o_done  = done_v[sel];
    assign o_lt    = lt_v[sel];
    assign o_lo    = lo_v[sel];
    assign o_aw    = aw_v[sel];
    assign o_ai    = ai_v[sel];

    always #5 clk = ~clk;

    // 0: 5x5 stride 1, 1: 5x5 stride 2, 2: 3x3 single window
    conv_window_addr_gen #(.KSIZE(3), .IMG_W(5), .IMG_H(5), .STRIDE(1), .AW_W(4), .AW_I(13)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .base_w(base_w), .base_i(base_i),
        .ready(ready), .valid(valid_v[0]), .addr_w(aw_v[0]), .addr_i(ai_v[0]),
        .last_tap(lt_v[0]), .last_out(lo_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    conv_window_addr_gen #(.KSIZE(3), .IMG_W(5), .IMG_H(5), .STRIDE(2), .AW_W(4), .AW_I(13)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .base_w(base_w), .base_i(base_i),
        .ready(ready), .valid(valid_v[1]), .addr_w(aw_v[1]), .addr_i(ai_v[1]),
        .last_tap(lt_v[1]), .last_out(lo_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    conv_window_addr_gen #(.KSIZE(3), .IMG_W(3), .IMG_H(3), .STRIDE(1), .AW_W(4), .AW_I(13)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .base_w(base_w), .base_i(base_i),
        .ready(ready), .valid(valid_v[2]), .addr_w(aw_v[2]), .addr_i(ai_v[2]),
        .last_tap(lt_v[2]), .last_out(lo_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    task automatic do_reset();
        rst_n   = 1'b0;
        start_v = '0;
        ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // mode 0: ready held high, 1: random ready, 2: two-cycle stall on the third tap
    task automatic run_sweep(input int s, input logic [3:0] bw, input logic [12:0] bi,
                             input int mode, input int abort_at);
        tap_t exp_q[$];
        tap_t e;
        int   k, w, h, st, ow, oh, n, idx, cyc, stalls;
        sel = s;
        k = 3;
        case (s)
            1:       begin w = 5; h = 5; st = 2; end
            2:       begin w = 3; h = 3; st = 1; end
            default: begin w = 5; h = 5; st = 1; end
        endcase
        ow = (w - k) / st + 1;
        oh = (h - k) / st + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int r = 0; r < k; r++)
                    for (int c = 0; c < k; c++) begin
                        e.aw = 4'((int'(bw) + r * k + c) % 16);
                        e.ai = 13'((int'(bi) + (oy * st + r) * w + ox * st + c) % 8192);
                        e.lt = (r == k - 1) && (c == k - 1);
                        e.lo = e.lt && (ox == ow - 1) && (oy == oh - 1);
                        exp_q.push_back(e);
                    end
        n = exp_q.size();

        base_w     = bw;
        base_i     = bi;
        ready      = 1'b1;
        start_v    = '0;
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v = '0;
        idx = 0; cyc = 0; stalls = 0;
        while (idx < n && cyc < 8 * n + 20) begin
            if (abort_at >= 0 && idx == abort_at) begin
                start_v = '0;
                rst_n   = 1'b0;
                @(negedge clk);
                checks++;
                if ({o_valid, o_busy, o_done, o_lt, o_lo, o_aw, o_ai} !== '0)
                    begin errors++; $display("FAIL abort_reset: valid=%b busy=%b done=%b aw=%0d ai=%0d, required all zero",
                                             o_valid, o_busy, o_done, o_aw, o_ai); end
                rst_n = 1'b1;
                @(negedge clk);
                checks++;
                if (o_done !== 1'b0 || o_valid !== 1'b0)
                    begin errors++; $display("FAIL abort_no_done: done=%b valid=%b, required 0 0", o_done, o_valid); end
                return;
            end
            case (mode)
                1:       ready = 1'($urandom_range(0, 1));
                2:       if (idx == 2 && stalls < 2) begin ready = 1'b0; stalls++; end
                         else ready = 1'b1;
                default: ready = 1'b1;
            endcase
            start_v[s] = 1'($urandom_range(0, 1));
            base_w     = 4'($urandom);
            base_i     = 13'($urandom);
            checks++;
            if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_done !== 1'b0) begin
                errors++;
                $display("FAIL run_ctl tap %0d: valid=%b busy=%b done=%b, required 1 1 0", idx, o_valid, o_busy, o_done);
                break;
            end
            checks++;
            if ({o_aw, o_ai, o_lt, o_lo} !== exp_q[idx])
                begin errors++; $display("FAIL tap %0d: aw=%0d ai=%0d lt=%b lo=%b, required aw=%0d ai=%0d lt=%b lo=%b",
                                         idx, o_aw, o_ai, o_lt, o_lo, exp_q[idx].aw, exp_q[idx].ai, exp_q[idx].lt, exp_q[idx].lo); end
            if (ready) idx++;
            @(negedge clk);
            cyc++;
        end
        start_v = '0;
        checks++;
        if (idx != n)
            begin errors++; $display("FAIL beat_count: got %0d beats, required %0d", idx, n); end
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b1)
            begin errors++; $display("FAIL done_pulse: valid=%b busy=%b done=%b, required 0 0 1", o_valid, o_busy, o_done); end
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v = '0;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0)
            begin errors++; $display("FAIL done_width: valid=%b busy=%b done=%b, required 0 0 0", o_valid, o_busy, o_done); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v = 3'($urandom);
            ready   = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({valid_v, busy_v, done_v, lt_v, lo_v} !== '0 ||
                {aw_v[0], aw_v[1], aw_v[2]} !== '0 || {ai_v[0], ai_v[1], ai_v[2]} !== '0)
                begin errors++; $display("FAIL reset_state: valid=%b busy=%b done=%b aw0=%0d ai0=%0d, required all zero",
                                         valid_v, busy_v, done_v, aw_v[0], ai_v[0]); end
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        run_sweep(0, 4'd0, 13'd100, 0, -1);
    endtask

    task automatic test_stall();
        do_reset();
        run_sweep(0, 4'd5, 13'd100, 2, -1);
        run_sweep(0, 4'($urandom), 13'($urandom), 1, -1);
    endtask

    task automatic test_stride2();
        do_reset();
        run_sweep(1, 4'd0, 13'd100, 0, -1);
        run_sweep(1, 4'($urandom), 13'($urandom), 1, -1);
    endtask

    task automatic test_abort();
        do_reset();
        run_sweep(0, 4'd3, 13'd200, 0, 20);
        run_sweep(0, 4'd3, 13'd200, 0, -1);
    endtask

    task automatic test_addr_wrap();
        do_reset();
        run_sweep(0, 4'd14, 13'd8190, 0, -1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_sweep(2, 4'd1, 13'd50, 0, -1);
        run_sweep(2, 4'($urandom), 13'($urandom), 1, -1);
        run_sweep(0, 4'($urandom), 13'($urandom), 1, -1);
    endtask

    initial begin
        sel     = 0;
        rst_n   = 1'b0;
        start_v = '0;
        base_w  = '0;
        base_i  = '0;
        ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_stride2();
        test_abort();
        test_addr_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
